// File: rtl/eq_axil_regs.sv
// rtl/eq_axil_regs.sv - AXI4-Lite slave exposing four 32-bit registers with byte strobes
// Also exports the register file and a one-cycle update strobe for each commit.
module eq_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [3:0]                      s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_o,
    output logic                            upd_o,
    output logic [1:0]                      upd_idx_o
);

    logic                                 rdy_en_q;
    logic                                 aw_held_q, w_held_q;
    logic                                 bvalid_q, rvalid_q, upd_q;
    logic [1:0]                           aw_idx_q, upd_idx_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]        wdata_q, rdata_q;
    logic [3:0]                           wstrb_q;
    logic [3:0][C_S_AXI_DATA_WIDTH-1:0]   regs_q, regs_d;
    logic                                 aw_fire, w_fire, ar_fire, commit;
    logic                                 unused_ok;

    // rdy_en_q keeps all READY outputs low while in reset and rises on the first edge after it.
    assign s00_axi_awready = rdy_en_q && !aw_held_q && !bvalid_q;
    assign s00_axi_wready  = rdy_en_q && !w_held_q && !bvalid_q;
    assign s00_axi_arready = rdy_en_q && !rvalid_q;

    assign aw_fire = s00_axi_awvalid && s00_axi_awready;
    assign w_fire  = s00_axi_wvalid && s00_axi_wready;
    assign ar_fire = s00_axi_arvalid && s00_axi_arready;
    assign commit  = aw_held_q && w_held_q;

    assign s00_axi_bvalid = bvalid_q;
    assign s00_axi_bresp  = 2'b00;
    assign s00_axi_rvalid = rvalid_q;
    assign s00_axi_rresp  = 2'b00;
    assign s00_axi_rdata  = rdata_q;
    assign reg_o          = regs_q;
    assign upd_o          = upd_q;
    assign upd_idx_o      = upd_idx_q;

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    always_comb begin
        regs_d = regs_q;
        if (commit) begin
            for (int k = 0; k < 4; k++) begin
                if (wstrb_q[k]) begin
                    regs_d[aw_idx_q][8*k +: 8] = wdata_q[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rdy_en_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            upd_q     <= 1'b0;
            aw_idx_q  <= 2'd0;
            upd_idx_q <= 2'd0;
            wdata_q   <= '0;
            wstrb_q   <= 4'd0;
            rdata_q   <= '0;
            regs_q    <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            upd_q    <= commit;
            regs_q   <= regs_d;
            if (aw_fire) begin
                aw_held_q <= 1'b1;
                aw_idx_q  <= s00_axi_awaddr[3:2];
            end
            if (w_fire) begin
                w_held_q <= 1'b1;
                wdata_q  <= s00_axi_wdata;
                wstrb_q  <= s00_axi_wstrb;
            end
            // Both READYs are low while both halves are held, so no fire can coincide with a commit.
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                upd_idx_q <= aw_idx_q;
            end else if (bvalid_q && s00_axi_bready) begin
                bvalid_q <= 1'b0;
            end
            // regs_q is sampled before this edge's commit lands, giving the pre-commit value.
            if (ar_fire) begin
                rdata_q  <= regs_q[s00_axi_araddr[3:2]];
                rvalid_q <= 1'b1;
            end else if (rvalid_q && s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule
